// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } par_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam int unsigned OSR       = 16;
  localparam int unsigned MID_START = 7;
  localparam int unsigned SCNT_W    = 4;
  localparam int unsigned BIT_CNT_W = 4;

  // Reserved mode is treated as no parity.
  function automatic logic par_enabled(input par_mode_e m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; head word is visible whenever not empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so the outputs read clean after reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes by aligning the pointers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampling, runtime parity, FIFO with per-word error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIVSR_W    = 10
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               rx,
  input  logic [DIVSR_W-1:0] divsr,
  input  logic [1:0]         par_mode,
  input  logic               rd_uart,
  input  logic               err_clr,
  output logic [DATA_W-1:0]  r_data,
  output logic               r_frame_err,
  output logic               r_parity_err,
  output logic               rx_empty,
  output logic               rx_full,
  output logic               overrun
);

  localparam int unsigned FW = DATA_W + 2;

  logic                 rx_m;
  logic                 rx_s;
  logic [DIVSR_W-1:0]   baud_cnt;
  logic                 tick;
  rx_state_e            state;
  logic                 armed;
  logic [SCNT_W-1:0]    s_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 stop_cnt;
  logic [DATA_W-1:0]    shreg;
  par_mode_e            par_q;
  logic                 par_err;
  logic                 frame_err;
  logic                 sample_c;
  logic                 last_stop_c;
  logic                 push_c;
  logic                 drop_c;
  logic [FW-1:0]        push_word_c;
  logic [FW-1:0]        head_c;

  // Two-flop synchronizer; resets low so a held-low line cannot arm the FSM.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Baud tick every divsr+1 clocks; >= keeps the wrap safe if divsr shrinks.
  assign tick = (baud_cnt >= divsr);

  always_ff @(posedge clk) begin
    if (Reset)     baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + DIVSR_W'(1);
  end

  assign sample_c    = tick && (s_cnt == SCNT_W'(OSR - 1));
  assign last_stop_c = (stop_cnt == 1'(STOP_BITS - 1));
  assign push_c      = (state == ST_STOP) && sample_c && last_stop_c;
  assign push_word_c = {par_err, frame_err | ~rx_s, shreg};

  // Receive FSM: start validation, LSB-first shift, parity and stop checks.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      s_cnt     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      par_q     <= PAR_NONE;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (tick) s_cnt <= s_cnt + SCNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (armed && !rx_s) begin
            s_cnt <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (tick && (s_cnt == SCNT_W'(MID_START))) begin
            if (!rx_s) begin
              s_cnt     <= '0;
              bit_cnt   <= '0;
              par_q     <= par_mode_e'(par_mode);
              par_err   <= 1'b0;
              frame_err <= 1'b0;
              state     <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (sample_c) begin
            shreg <= {rx_s, shreg[DATA_W-1:1]};
            if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
              bit_cnt  <= '0;
              stop_cnt <= 1'b0;
              state    <= par_enabled(par_q) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        ST_PARITY: begin
          if (sample_c) begin
            par_err  <= (^shreg) ^ rx_s ^ (par_q == PAR_ODD);
            stop_cnt <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample_c) begin
            frame_err <= frame_err | ~rx_s;
            if (last_stop_c) state    <= ST_IDLE;
            else             stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign drop_c = push_c && rx_full && !rd_uart;

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (Reset) overrun <= 1'b0;
    else       overrun <= (overrun & ~err_clr) | drop_c;
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .Reset (Reset),
    .push  (push_c),
    .pop   (rd_uart),
    .din   (push_word_c),
    .dout  (head_c),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign r_data       = head_c[DATA_W-1:0];
  assign r_frame_err  = head_c[DATA_W];
  assign r_parity_err = head_c[DATA_W+1];

endmodule
